and_chk: RTL and testbench

AND_CHK -- requirements
Module: and_chk

---
 rtl/and_chk.sv | 132 +++++++++++++
 tb/tb_and_chk.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/and_chk.sv
// rtl/and_chk.sv - run-based checker comparing Y against a LAT-delayed A&B reference
// Optional first-mismatch index capture: define AND_CHK_FIRST_ERR_EN.
module and_chk #(
    parameter int NUM_STIM = 100,
    parameter int LAT      = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             A,
    input  logic             B,
    input  logic             Y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int               IDX_W     = (NUM_STIM > 2) ? $clog2(NUM_STIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STIM - 1);
    localparam logic [2:0]       FILL_LAST = 3'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [2:0]       fill_cnt;
    logic             ab;
    logic             expected;
    logic             match;
    logic             shift_en;
    logic             start_run;

    assign ab        = A & B;
    assign shift_en  = (state == FILL) || (state == RUN);
    assign match     = (Y == expected);
    assign start_run = start && ((state == IDLE) || (state == DONE));

    // Reference path: LAT-deep shift line of A&B; LAT=0 compares against same-edge A&B.
    generate
        if (LAT == 0) begin : g_nodelay
            assign expected = ab;
        end else begin : g_delay
            logic [LAT-1:0] line;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    line <= '0;
                end else if (shift_en) begin
                    line <= (line << 1) | LAT'(ab);
                end
            end
            assign expected = line[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= '0;
            fill_cnt <= '0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= (LAT > 0) ? FILL : RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        idx      <= '0;
                        fill_cnt <= '0;
                        pass_cnt <= '0;
                        err_cnt  <= '0;
                        err_flag <= 1'b0;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt + 3'd1;
                    if (fill_cnt == FILL_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Counters saturate; idx keeps the true compare index for run length.
                    if (match) begin
                        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                        err_flag <= 1'b1;
                    end
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AND_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_q <= '0;
        end else if (start_run) begin
            first_err_q <= '0;
        end else if ((state == RUN) && !match && !err_flag) begin
            first_err_q <= CNT_W'(idx);
        end
    end

    assign first_err_idx = first_err_q;
`else
    assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_and_chk.sv
// tb/tb_and_chk.sv - table-driven randomized bench for and_chk across four parameter sets
module tb_and_chk;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_v [4];
    logic a_v [4];
    logic b_v [4];
    logic y_v [4];

    logic        busy0, done0, flag0, busy1, done1, flag1, busy2, done2, flag2, busy3, done3, flag3;
    logic [15:0] pass0, err0, fei0, pass1, err1, fei1, pass3, err3, fei3;
    logic [2:0]  pass2, err2, fei2;

    logic busy_v [4];
    logic done_v [4];
    logic flag_v [4];
    int   pass_v [4];
    int   err_v [4];
    int   fei_v [4];

    always_comb begin
        busy_v[0] = busy0; done_v[0] = done0; flag_v[0] = flag0;
        busy_v[1] = busy1; done_v[1] = done1; flag_v[1] = flag1;
        busy_v[2] = busy2; done_v[2] = done2; flag_v[2] = flag2;
        busy_v[3] = busy3; done_v[3] = done3; flag_v[3] = flag3;
        pass_v[0] = int'(pass0); err_v[0] = int'(err0); fei_v[0] = int'(fei0);
        pass_v[1] = int'(pass1); err_v[1] = int'(err1); fei_v[1] = int'(fei1);
        pass_v[2] = int'(pass2); err_v[2] = int'(err2); fei_v[2] = int'(fei2);
        pass_v[3] = int'(pass3); err_v[3] = int'(err3); fei_v[3] = int'(fei3);
    end

    and_chk #(.NUM_STIM(100), .LAT(1), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .Y(y_v[0]),
        .busy(busy0), .done(done0), .pass_cnt(pass0), .err_cnt(err0),
        .err_flag(flag0), .first_err_idx(fei0));

    and_chk #(.NUM_STIM(4), .LAT(0), .CNT_W(16)) u_lat0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .Y(y_v[1]),
        .busy(busy1), .done(done1), .pass_cnt(pass1), .err_cnt(err1),
        .err_flag(flag1), .first_err_idx(fei1));

    and_chk #(.NUM_STIM(12), .LAT(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .Y(y_v[2]),
        .busy(busy2), .done(done2), .pass_cnt(pass2), .err_cnt(err2),
        .err_flag(flag2), .first_err_idx(fei2));

    and_chk #(.NUM_STIM(20), .LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .A(a_v[3]), .B(b_v[3]), .Y(y_v[3]),
        .busy(busy3), .done(done3), .pass_cnt(pass3), .err_cnt(err3),
        .err_flag(flag3), .first_err_idx(fei3));

    localparam int LAT_OF [4] = '{1, 0, 1, 3};
    localparam int N_OF   [4] = '{100, 4, 12, 20};
    localparam int CW_OF  [4] = '{16, 16, 3, 16};

`ifdef AND_CHK_FIRST_ERR_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    // pat: 0 random A/B, 1 A=B=1, 2 A=B=0 with Y stuck at 1. exp_* < 0 means model-only.
    typedef struct {
        int sel;
        int pat;
        int inj0;
        int inj1;
        int start_at;
        int exp_pass;
        int exp_err;
        int exp_flag;
        int exp_fei;
    } vec_t;

    vec_t tbl [7];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_run(input int r, input int abort_at);
        int sel, lat, n, sat, pm, em, fm, fem, k, hold_pass;
        bit a, b, yv, flip;
        bit ab [$];
        sel = tbl[r].sel;
        lat = LAT_OF[sel];
        n   = N_OF[sel];
        sat = (1 << CW_OF[sel]) - 1;
        pm = 0; em = 0; fm = 0; fem = 0;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        chk($sformatf("clear_pass r%0d", r), pass_v[sel], 0);
        chk($sformatf("clear_err r%0d", r), err_v[sel], 0);
        chk($sformatf("clear_flag r%0d", r), int'(flag_v[sel]), 0);
        for (int c = 0; c < lat + n; c++) begin
            if (c == abort_at) return;
            chk($sformatf("busy r%0d c%0d", r, c), int'(busy_v[sel]), 1);
            chk($sformatf("done_low r%0d c%0d", r, c), int'(done_v[sel]), 0);
            start_v[sel] = (c == tbl[r].start_at);
            case (tbl[r].pat)
                1:       begin a = 1'b1; b = 1'b1; end
                2:       begin a = 1'b0; b = 1'b0; end
                default: begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
            endcase
            a_v[sel] = a;
            b_v[sel] = b;
            ab.push_back(a & b);
            if (c >= lat) begin
                // Reference: sample k is judged against A&B applied LAT cycles earlier.
                k = c - lat;
                flip = (tbl[r].pat == 2) || (k == tbl[r].inj0) || (k == tbl[r].inj1);
                yv = ab[k] ^ flip;
                if (!flip) begin
                    pm = (pm < sat) ? pm + 1 : sat;
                end else begin
                    em = (em < sat) ? em + 1 : sat;
                    if (FE_ON && fm == 0) fem = k & sat;
                    fm = 1;
                end
            end else begin
                yv = 1'($urandom_range(0, 1));
            end
            y_v[sel] = yv;
            @(negedge clk);
            start_v[sel] = 1'b0;
            chk($sformatf("pass r%0d c%0d", r, c), pass_v[sel], pm);
            chk($sformatf("err r%0d c%0d", r, c), err_v[sel], em);
            chk($sformatf("flag r%0d c%0d", r, c), int'(flag_v[sel]), fm);
        end
        chk($sformatf("done r%0d", r), int'(done_v[sel]), 1);
        chk($sformatf("busy_end r%0d", r), int'(busy_v[sel]), 0);
        chk($sformatf("fei r%0d", r), fei_v[sel], fem);
        if (tbl[r].exp_pass >= 0) begin
            chk($sformatf("tbl_pass r%0d", r), pass_v[sel], tbl[r].exp_pass);
            chk($sformatf("tbl_err r%0d", r), err_v[sel], tbl[r].exp_err);
            chk($sformatf("tbl_flag r%0d", r), int'(flag_v[sel]), tbl[r].exp_flag);
            chk($sformatf("tbl_fei r%0d", r), fei_v[sel], tbl[r].exp_fei);
        end
        hold_pass = pm;
        @(negedge clk);
        chk($sformatf("done_hold r%0d", r), int'(done_v[sel]), 1);
        chk($sformatf("pass_hold r%0d", r), pass_v[sel], hold_pass);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0; a_v[i] = 1'b0; b_v[i] = 1'b0; y_v[i] = 1'b0;
        end
        tbl[0] = '{0, 0, -1, -1, -1, 100, 0, 0, 0};
        tbl[1] = '{0, 0, 5, 37, -1, 98, 2, 1, FE_ON ? 5 : 0};
        tbl[2] = '{1, 1, -1, -1, -1, 4, 0, 0, 0};
        tbl[3] = '{2, 2, -1, -1, -1, 0, 7, 1, 0};
        tbl[4] = '{3, 0, int'($urandom_range(0, 19)), int'($urandom_range(0, 19)), -1, -1, -1, -1, -1};
        tbl[5] = '{0, 0, -1, -1, 11, 100, 0, 0, 0};
        tbl[6] = '{0, 0, int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), -1, -1, -1, -1, -1};

        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_busy s%0d", i), int'(busy_v[i]), 0);
            chk($sformatf("rst_done s%0d", i), int'(done_v[i]), 0);
            chk($sformatf("rst_pass s%0d", i), pass_v[i], 0);
            chk($sformatf("rst_err s%0d", i), err_v[i], 0);
            chk($sformatf("rst_flag s%0d", i), int'(flag_v[i]), 0);
        end
        @(negedge clk);
        #2 rst = 1'b0;

        for (int r = 0; r < 7; r++) begin
            do_run(r, -1);
        end

        // Asynchronous reset in the middle of a run, just before compare index 50.
        do_run(0, 51);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_pass", int'(pass0), 0);
        chk("midrst_err", int'(err0), 0);
        chk("midrst_flag", int'(flag0), 0);
        chk("midrst_fei", int'(fei0), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_busy %0d", i), int'(busy0), 0);
            chk($sformatf("idle_done %0d", i), int'(done0), 0);
        end
        do_run(1, -1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
